// File: rtl/proc_stat_pkg.sv
// Shared definitions for the statistics memory: word layout and the read-arbiter state type.
package proc_stat_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } t_arb_state;

  // Layout: G_MODS min/max pairs first, then one average word per module.
  localparam int C_MODS        = 4;
  localparam int C_MINMAX_BASE = 0;
  localparam int C_AVG_BASE    = C_MODS * 2;
  localparam int C_STAT_WORDS  = C_MODS * 3;

endpackage

// File: rtl/proc_rr_arb.sv
// Combinational round-robin picker: first set request scanning upward from ptr+1, wrapping.
module proc_rr_arb #(
  parameter int G_REQS  = 2,
  parameter int G_PTR_W = $clog2(G_REQS)
) (
  input  logic [G_REQS-1:0]  req,
  input  logic [G_PTR_W-1:0] ptr,
  output logic [G_REQS-1:0]  grant,
  output logic [G_PTR_W-1:0] grant_idx,
  output logic               any
);

  int k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    k         = 0;
    // The last winner (ptr) is visited last, so it cannot win twice while others wait.
    for (int i = 1; i <= G_REQS; i++) begin
      k = (int'(ptr) + i) % G_REQS;
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = G_PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/proc_stat_rd_arb.sv
// Round-robin sharing of the single stat-memory read port; one read in flight, fixed latency.
module proc_stat_rd_arb
  import proc_stat_pkg::*;
#(
  parameter int G_REQS     = 2,
  parameter int G_ADDR_W   = 4,
  parameter int G_ADDR_NUM = C_STAT_WORDS,
  parameter int G_DATA_W   = 64,
  parameter int G_MEM_LAT  = 2
) (
  input  logic                             i_clk,
  input  logic                             i_aresetn,
  input  logic [G_REQS-1:0]                s_req_valid,
  input  logic [G_REQS-1:0][G_ADDR_W-1:0]  s_req_addr,
  output logic [G_REQS-1:0]                s_req_ready,
  output logic [G_REQS-1:0]                s_rsp_valid,
  input  logic [G_REQS-1:0]                s_rsp_ready,
  output logic [G_DATA_W-1:0]              s_rsp_data,
  output logic                             s_rsp_err,
  output logic                             o_mem_rd_en,
  output logic [G_ADDR_W-1:0]              o_mem_rd_addr,
  input  logic [G_DATA_W-1:0]              i_mem_rd_data,
  output logic                             o_busy,
  output t_arb_state                       o_dbg_state
);

  // Handshakes: a request transfers in the IDLE cycle where s_req_valid[g] and s_req_ready[g]
  // are both high; a response transfers when s_rsp_valid[g] and s_rsp_ready[g] are both high,
  // and data/err stay stable from s_rsp_valid rising until that transfer.

  localparam int PW = $clog2(G_REQS);
  localparam int CW = $clog2(G_MEM_LAT + 1);

  t_arb_state          state_q, state_d;
  logic [PW-1:0]       ptr_q;
  logic [G_REQS-1:0]   gnt_q;
  logic [G_ADDR_W-1:0] addr_q;
  logic [CW-1:0]       cnt_q;
  logic [G_DATA_W-1:0] data_q;
  logic                err_q;

  logic [G_REQS-1:0]   grant;
  logic [PW-1:0]       grant_idx;
  logic                any_req;
  logic [G_ADDR_W-1:0] sel_addr;
  logic                addr_err;

  proc_rr_arb #(
    .G_REQS  (G_REQS),
    .G_PTR_W (PW)
  ) u_rr_arb (
    .req       (s_req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any_req)
  );

  assign sel_addr = s_req_addr[grant_idx];
  assign addr_err = (int'(sel_addr) >= G_ADDR_NUM);

  always_comb begin
    state_d     = state_q;
    s_req_ready = '0;
    s_rsp_valid = '0;
    o_mem_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          s_req_ready = grant;
          state_d     = addr_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        o_mem_rd_en = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
      end
      RESP: begin
        s_rsp_valid = gnt_q;
        if (|(s_rsp_ready & gnt_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= IDLE;
      ptr_q   <= PW'(G_REQS - 1);
      gnt_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q  <= grant;
            addr_q <= sel_addr;
            ptr_q  <= grant_idx;
            data_q <= '0;
            err_q  <= addr_err;
          end
        end
        ISSUE: cnt_q <= CW'(G_MEM_LAT - 1);
        WAIT: begin
          // Count 0 lands exactly on the cycle the memory word is valid.
          if (cnt_q == '0) data_q <= i_mem_rd_data;
          else             cnt_q  <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_rsp_data    = data_q;
  assign s_rsp_err     = err_q;
  assign o_mem_rd_addr = addr_q;
  assign o_busy        = (state_q != IDLE);
  assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_proc_stat_rd_arb.sv
// Directed bench for proc_stat_rd_arb: scoreboard queues filled by the tests, drained by monitors.
module tb_proc_stat_rd_arb;
  import proc_stat_pkg::*;

  typedef struct packed {
    logic [1:0]  idx;
    logic        err;
    logic [3:0]  lat;
    logic [63:0] data;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: 2 requesters, latency 2
  logic [1:0]       req_valid = '0;
  logic [1:0][3:0]  req_addr = '0;
  logic [1:0]       req_ready, rsp_valid;
  logic [1:0]       rsp_ready = '1;
  logic [63:0]      rsp_data, rd_data;
  logic             rsp_err, rd_en, busy;
  logic [3:0]       rd_addr;
  t_arb_state       st_a;

  // Second instance: 3 requesters, latency 1
  logic [2:0]       v3 = '0;
  logic [2:0][3:0]  a3 = '0;
  logic [2:0]       rdy3, rv3;
  logic [2:0]       rr3 = '1;
  logic [63:0]      d3, md3;
  logic             e3, en3, busy3;
  logic [3:0]       ad3;
  t_arb_state       st3;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp3_q[$];

  proc_stat_rd_arb #(.G_REQS(2), .G_ADDR_W(4), .G_ADDR_NUM(12), .G_DATA_W(64), .G_MEM_LAT(2)) u_dut (
    .i_clk(clk), .i_aresetn(rst_n),
    .s_req_valid(req_valid), .s_req_addr(req_addr), .s_req_ready(req_ready),
    .s_rsp_valid(rsp_valid), .s_rsp_ready(rsp_ready), .s_rsp_data(rsp_data), .s_rsp_err(rsp_err),
    .o_mem_rd_en(rd_en), .o_mem_rd_addr(rd_addr), .i_mem_rd_data(rd_data),
    .o_busy(busy), .o_dbg_state(st_a)
  );

  proc_stat_rd_arb #(.G_REQS(3), .G_ADDR_W(4), .G_ADDR_NUM(12), .G_DATA_W(64), .G_MEM_LAT(1)) u_dut3 (
    .i_clk(clk), .i_aresetn(rst_n),
    .s_req_valid(v3), .s_req_addr(a3), .s_req_ready(rdy3),
    .s_rsp_valid(rv3), .s_rsp_ready(rr3), .s_rsp_data(d3), .s_rsp_err(e3),
    .o_mem_rd_en(en3), .o_mem_rd_addr(ad3), .i_mem_rd_data(md3),
    .o_busy(busy3), .o_dbg_state(st3)
  );

  // Memory models: word is driven only in the exact valid cycle, garbage otherwise.
  logic [63:0] mem [16];
  logic [3:0]  ap0, ap1, ap3;
  logic        vp0 = 1'b0, vp1 = 1'b0, vp3 = 1'b0;
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {16'hBEEF, 12'h000, 4'(i), 32'h0000_1000 + 32'(i)};
    mem[3] = 64'h0000_0000_0000_00A5;
  end
  always @(posedge clk) begin
    vp0 <= rd_en; ap0 <= rd_addr; vp1 <= vp0; ap1 <= ap0;
    vp3 <= en3;   ap3 <= ad3;
  end
  assign rd_data = vp1 ? mem[ap1] : 64'hDEAD_DEAD_DEAD_DEAD;
  assign md3     = vp3 ? mem[ap3] : 64'hDEAD_DEAD_DEAD_DEAD;

  int rd_cnt = 0;
  always @(posedge clk) if (rd_en) rd_cnt <= rd_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  task automatic push(input int which, input int idx, input logic err, input int lat,
                      input logic [63:0] d);
    exp_t e;
    e.idx = 2'(idx); e.err = err; e.lat = 4'(lat); e.data = d;
    if (which == 0) exp_q.push_back(EW'(e));
    else            exp3_q.push_back(EW'(e));
  endtask

  // Caller is positioned just after a posedge; valid stays high until the accept cycle ends.
  task automatic do_req(input int r, input logic [3:0] a);
    logic got;
    got = 1'b0;
    req_valid[r] = 1'b1;
    req_addr[r]  = a;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (req_ready[r]) begin got = 1'b1; break; end
    end
    chk($sformatf("req%0d_accept_timeout", r), 64'(got), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp3_q.size() == 0 && !busy && !busy3) begin ok = 1'b1; break; end
    end
    chk("drain_timeout", 64'(ok), 64'd1);
  endtask

  // Monitor, main instance
  initial begin : mon_a
    int hs_c, first_c;
    logic in_rsp;
    exp_t e;
    hs_c = 0; first_c = 0; in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_rsp = 1'b0;
      else begin
        if (|(req_valid & req_ready)) hs_c = cyc;
        if (|rsp_valid && !in_rsp) begin in_rsp = 1'b1; first_c = cyc; end
        if (|(rsp_valid & rsp_ready)) begin
          in_rsp = 1'b0;
          chk("a_req_ready_at_rsp_hs", 64'(req_ready), 64'd0);
          if (exp_q.size() == 0) chk("a_unexpected_rsp", 64'(rsp_valid), 64'd0);
          else begin
            e = exp_t'(exp_q.pop_front());
            chk("a_rsp_grant", 64'(rsp_valid), 64'd1 << e.idx);
            chk("a_rsp_data", rsp_data, e.data);
            chk("a_rsp_err", 64'(rsp_err), 64'(e.err));
            chk("a_rsp_latency", 64'(first_c - hs_c), 64'(e.lat));
          end
        end
      end
    end
  end

  // Monitor, 3-requester instance
  initial begin : mon_3
    int hs_c, first_c;
    logic in_rsp;
    exp_t e;
    hs_c = 0; first_c = 0; in_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) in_rsp = 1'b0;
      else begin
        if (|(v3 & rdy3)) hs_c = cyc;
        if (|rv3 && !in_rsp) begin in_rsp = 1'b1; first_c = cyc; end
        if (|(rv3 & rr3)) begin
          in_rsp = 1'b0;
          if (exp3_q.size() == 0) chk("b_unexpected_rsp", 64'(rv3), 64'd0);
          else begin
            e = exp_t'(exp3_q.pop_front());
            chk("b_rsp_grant", 64'(rv3), 64'd1 << e.idx);
            chk("b_rsp_data", d3, e.data);
            chk("b_rsp_err", 64'(e3), 64'(e.err));
            chk("b_rsp_latency", 64'(first_c - hs_c), 64'(e.lat));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0] g;
    logic       got;
    int         seen;
    int         rd_before;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_state", 64'(st_a), 64'(IDLE));
    @(posedge clk); #1; rst_n = 1'b1;

    // 1: single read, addr 3
    @(posedge clk); #1;
    push(0, 0, 1'b0, 4, 64'h0000_0000_0000_00A5);
    do_req(0, 4'd3);
    @(negedge clk);
    chk("t1_rd_en", 64'(rd_en), 64'd1);
    chk("t1_rd_addr", 64'(rd_addr), 64'd3);
    drain();

    // 2: both held after reset -> 0,1,0,1 (addr 11 is the last valid word)
    pulse_reset();
    push(0, 0, 1'b0, 4, 64'hBEEF_0000_0000_1000);
    push(0, 1, 1'b0, 4, 64'hBEEF_0005_0000_1005);
    push(0, 0, 1'b0, 4, 64'hBEEF_000B_0000_100B);
    push(0, 1, 1'b0, 4, 64'hBEEF_0001_0000_1001);
    fork
      begin do_req(0, 4'd0); do_req(0, 4'd11); end
      begin do_req(1, 4'd5); do_req(1, 4'd1); end
    join
    drain();

    // 3: out-of-range address answered locally
    rd_before = rd_cnt;
    @(posedge clk); #1;
    push(0, 1, 1'b1, 1, 64'd0);
    do_req(1, 4'd12);
    drain();
    chk("t3_no_rd_en", 64'(rd_cnt - rd_before), 64'd0);

    // 4: response back-pressure with req1 pending
    rsp_ready[0] = 1'b0;
    push(0, 0, 1'b0, 4, 64'hBEEF_0007_0000_1007);
    push(0, 1, 1'b0, 4, 64'hBEEF_0009_0000_1009);
    @(posedge clk); #1;
    fork
      do_req(0, 4'd7);
      begin @(posedge clk); #1; do_req(1, 4'd9); end
    join_none
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rsp_valid[0]) begin got = 1'b1; break; end
    end
    chk("t4_rsp_valid_timeout", 64'(got), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("t4_data_stable", rsp_data, 64'hBEEF_0007_0000_1007);
      chk("t4_req1_held_off", 64'(req_ready[1]), 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1; rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t4_req1_not_at_hs", 64'(req_ready[1]), 64'd0);
    @(negedge clk);
    chk("t4_req1_after_hs", 64'(req_ready[1]), 64'd1);
    drain();

    // 5: async reset during WAIT drops the read
    @(posedge clk); #1;
    do_req(0, 4'd2);
    @(negedge clk);
    chk("t5_rd_en", 64'(rd_en), 64'd1);
    @(negedge clk);
    chk("t5_in_wait", 64'(st_a), 64'(WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy_async", 64'(busy), 64'd0);
    chk("t5_rsp_valid_async", 64'(rsp_valid), 64'd0);
    chk("t5_rsp_data_async", rsp_data, 64'd0);
    chk("t5_rd_en_async", 64'(rd_en), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (|rsp_valid) seen++;
    end
    chk("t5_no_late_rsp", 64'(seen), 64'd0);
    push(0, 0, 1'b0, 4, 64'hBEEF_0004_0000_1004);
    push(0, 1, 1'b0, 4, 64'hBEEF_000A_0000_100A);
    @(posedge clk); #1;
    fork
      do_req(0, 4'd4);
      do_req(1, 4'd10);
    join
    drain();

    // 6: 3 requesters, latency 1 -> order 0,1,2, rsp at T+3
    pulse_reset();
    push(1, 0, 1'b0, 3, 64'hBEEF_0001_0000_1001);
    push(1, 1, 1'b0, 3, 64'hBEEF_0004_0000_1004);
    push(1, 2, 1'b0, 3, 64'hBEEF_000A_0000_100A);
    a3[0] = 4'd1; a3[1] = 4'd4; a3[2] = 4'd10;
    v3 = 3'b111;
    for (int n = 0; n < 3; n++) begin
      got = 1'b0; g = 3'b111;
      for (int m = 0; m < 100; m++) begin
        @(negedge clk);
        if (|(v3 & rdy3)) begin g = v3 & rdy3; got = 1'b1; break; end
      end
      chk("t6_accept_timeout", 64'(got), 64'd1);
      @(posedge clk); #1;
      v3 = v3 & ~g;
    end
    drain();

    chk("end_exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("end_exp3_q_empty", 64'(exp3_q.size()), 64'd0);
    chk("end_dut3_idle", 64'(st3), 64'(IDLE));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
